// File: rtl/qpsk_symbol_packer.sv
// rtl/qpsk_symbol_packer.sv - byte FIFO feeding a dibit serializer that holds each QPSK symbol for SYMBOL_CYCLES clocks
module qpsk_symbol_packer #(
    parameter int         SYMBOL_CYCLES = 20,
    parameter int         FIFO_DEPTH    = 4,
    parameter bit         MSB_FIRST     = 1'b1,
    parameter logic [1:0] IDLE_SYM      = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] out,
    output logic       out_valid,
    output logic       sym_strobe,
    output logic       underflow
);

    localparam int CW   = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      byte_q, byte_d;
    logic [1:0]      out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            sym_strobe_q, sym_strobe_d;
    logic            underflow_q, underflow_d;

    logic            boundary;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            need_byte;
    logic [7:0]      head;

    // Transmission position k maps to a byte bit-pair; MSB_FIRST reverses the walk.
    function automatic logic [1:0] dibit_sel(input logic [7:0] b, input logic [1:0] k);
        logic [1:0] pos;
        pos = MSB_FIRST ? (2'd3 - k) : k;
        return b[{pos, 1'b0} +: 2];
    endfunction

    assign boundary  = (cnt_q == CW'(SYMBOL_CYCLES - 1));
    assign full      = (count_q == CNTW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign need_byte = boundary && ((state_q == ST_IDLE) || (idx_q == 2'd3));
    assign pop       = need_byte && !empty;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d    = boundary ? '0 : cnt_q + CW'(1);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNTW'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        byte_d       = byte_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        sym_strobe_d = boundary;
        underflow_d  = 1'b0;
        if (boundary) begin
            if ((state_q == ST_SHIFT) && (idx_q != 2'd3)) begin
                idx_d = idx_q + 2'd1;
                out_d = dibit_sel(byte_q, idx_q + 2'd1);
            end else if (!empty) begin
                state_d     = ST_SHIFT;
                idx_d       = 2'd0;
                byte_d      = head;
                out_d       = dibit_sel(head, 2'd0);
                out_valid_d = 1'b1;
            end else begin
                // Running dry mid-stream is an underflow; staying idle is not.
                state_d     = ST_IDLE;
                idx_d       = 2'd0;
                out_d       = IDLE_SYM;
                out_valid_d = 1'b0;
                underflow_d = (state_q == ST_SHIFT);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            byte_q       <= 8'h00;
            out_q        <= IDLE_SYM;
            out_valid_q  <= 1'b0;
            sym_strobe_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            byte_q       <= byte_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            sym_strobe_q <= sym_strobe_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign sym_strobe = sym_strobe_q;
    assign underflow  = underflow_q;

endmodule

// File: doc/qpsk_symbol_packer.md
QPSK_SYMBOL_PACKER -- requirements
Module: qpsk_symbol_packer

Interface
REQ-001 Parameter SYMBOL_CYCLES, default 20, clock cycles each dibit is held on out; legal range >= 1.
REQ-002 Parameter FIFO_DEPTH, default 4, byte FIFO entries; power of two, >= 2.
REQ-003 Parameter MSB_FIRST, default 1, 1 = bits[7:6] sent first, 0 = bits[1:0] sent first.
REQ-004 Parameter IDLE_SYM, default 2'b00, dibit driven on out while no data is sent.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 in_data  input  8  byte to transmit.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  FIFO can accept a byte; equals !full, combinational from FIFO count only.
REQ-010 out  output  2  current symbol; drives the qpsk_modulator in port; registered.
REQ-011 out_valid  output  1  out carries payload, not IDLE_SYM; registered.
REQ-012 sym_strobe  output  1  one-cycle pulse in the first cycle of every new symbol period; registered.
REQ-013 underflow  output  1  one-cycle pulse when a payload stream ends because the FIFO is empty; registered.

Function
REQ-014 Byte accepted on a rising edge with in_valid && in_ready; in_data is held in the FIFO in arrival order.
REQ-015 Pushes into a full FIFO are not possible; a same-edge pop does not allow a push.
REQ-016 Symbol timer cnt runs freely from 0 to SYMBOL_CYCLES-1, then wraps to 0.
REQ-017 Boundary edge: rising edge with cnt == SYMBOL_CYCLES-1; with SYMBOL_CYCLES=1, every edge.
REQ-018 States: IDLE (no byte loaded), SHIFT (byte loaded, dibit index 0..3).
REQ-019 On a boundary edge in SHIFT with index < 3: index increments; out gets the next dibit; out_valid stays 1.
REQ-020 On a boundary edge in IDLE, or in SHIFT with index == 3, with FIFO non-empty: pop one byte; out gets its first dibit; index = 0; out_valid = 1; state = SHIFT.
REQ-021 On a boundary edge in IDLE, or in SHIFT with index == 3, with FIFO empty: state = IDLE; out = IDLE_SYM; out_valid = 0.
REQ-022 underflow pulses for the cycle after the boundary edge where SHIFT goes to IDLE; it never pulses while already in IDLE.
REQ-023 Dibit order: MSB_FIRST=1 gives [7:6],[5:4],[3:2],[1:0]; MSB_FIRST=0 gives [1:0],[3:2],[5:4],[7:6].
REQ-024 sym_strobe is 1 in the cycle after every boundary edge, including idle periods.
REQ-025 out and out_valid change only on boundary edges or reset.
REQ-026 Consecutive bytes stream with no gap and no idle symbol if each next byte is in the FIFO before the index-3 boundary edge.
REQ-027 A byte written on edge N can be popped no earlier than edge N+1; there is no fall-through.
REQ-028 Latency from push into an empty FIFO in IDLE to out change is the next boundary edge after the push edge, at most SYMBOL_CYCLES cycles.

Reset
REQ-029 While rst=1: cnt=0, FIFO emptied, state=IDLE, index=0, out=IDLE_SYM, out_valid=0, sym_strobe=0, underflow=0, in_ready=1.
REQ-030 Reset asserted mid-symbol or mid-byte discards the loaded byte and the FIFO contents immediately, without waiting for a clock edge.
REQ-031 After rst falls, the first boundary edge is the SYMBOL_CYCLES-th rising edge.

Verification
REQ-032 Defaults; push 0xB4 once -> out = 10, 11, 01, 00, each held 20 cycles with out_valid=1; then out=00, out_valid=0; one underflow pulse.
REQ-033 MSB_FIRST=0; push 0xB4 -> out = 00, 01, 11, 10; sym_strobe pulses every 20 cycles, including idle periods.
REQ-034 Hold in_valid with 6 bytes 0x00..0x05 while the FIFO is full -> in_ready drops after 4 buffered bytes; all 6 bytes are sent in order as 24 contiguous symbols; no idle symbol; underflow only after the last byte.
REQ-035 Reset asserted at cycle 7 of the 2nd dibit of 0xFF with 2 bytes queued -> out=00, out_valid=0, in_ready=1 at once; after release, nothing is sent until a new push.
REQ-036 SYMBOL_CYCLES=1; push 0x1B -> out changes every cycle: 00, 01, 10, 11; sym_strobe is constantly 1.
REQ-037 Push lands on the same edge as an idle boundary -> byte is sent at the following boundary, SYMBOL_CYCLES cycles later, not on that edge.
